// File: rtl/wt_frame_unpacker_pkg.sv
// Shared constants, FSM encoding and width helper for the turbine frame unpacker.
package wt_frame_unpacker_pkg;

  localparam int N_WindTurbine   = 4;
  localparam int WT_DATA_W       = 64;
  // Enable generation, FIFO q, then the FIFO output register.
  localparam int WT_READ_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wt_frame_unpacker_if.sv
// Frame-unpacker bus: FIFO-side capture inputs and the network-side readout.
interface wt_frame_unpacker_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_done;
  logic              busy;
  logic              active_bank;
  logic              overrun;
  logic [15:0]       frame_cnt;

  modport master (
    output start, din, rd_addr,
    input  rd_data, frame_done, busy, active_bank, overrun, frame_cnt
  );

  modport slave (
    input  start, din, rd_addr,
    output rd_data, frame_done, busy, active_bank, overrun, frame_cnt
  );
endinterface

// File: rtl/wt_pingpong_bank.sv
// Two banks of N_WT words: one write port into either bank, one registered read port.
module wt_pingpong_bank
  import wt_frame_unpacker_pkg::*;
#(
  parameter int N_WT   = N_WindTurbine,
  parameter int DATA_W = WT_DATA_W,
  parameter int ADDR_W = clog2_min1(N_WT),
  parameter int IDX_W  = clog2_min1(N_WT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              wr_bank_i,
  input  logic [IDX_W-1:0]  wr_slot_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [ADDR_W:0] N_WT_A = (ADDR_W + 1)'(N_WT);

  logic [DATA_W-1:0] mem_q [2][N_WT];
  logic [DATA_W-1:0] rd_data_q;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_in_range;

  assign rd_in_range = ({1'b0, rd_addr_i} < N_WT_A);
  assign rd_idx      = rd_addr_i[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < N_WT; s++) begin
          mem_q[b][s] <= '0;
        end
      end
      rd_data_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[wr_bank_i][wr_slot_i] <= wr_data_i;
      end
      rd_data_q <= rd_in_range ? mem_q[rd_bank_i][rd_idx] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wt_frame_unpacker.sv
// Captures N_WT FIFO words per frame into the idle bank and commits them by bank swap.
// IDLE wait start | WAIT read latency | CAPTURE write N_WT words | DONE swap banks
module wt_frame_unpacker
  import wt_frame_unpacker_pkg::*;
#(
  parameter int N_WT         = N_WindTurbine,
  parameter int DATA_W       = WT_DATA_W,
  parameter int READ_LATENCY = WT_READ_LATENCY,
  parameter int ADDR_W       = clog2_min1(N_WT)
) (
  input  logic clk,
  input  logic rst,
  wt_frame_unpacker_if.slave bus
);

  localparam int IDX_W = clog2_min1(N_WT);
  localparam int LAT_W = clog2_min1(READ_LATENCY);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(N_WT - 1);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic              active_bank_q, active_bank_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              cap_we;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    k_d     = k_q;
    cap_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          k_d = '0;
          if (READ_LATENCY == 1) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) state_d = ST_CAPTURE;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      ST_CAPTURE: begin
        cap_we = 1'b1;
        if (k_q == K_LAST) state_d = ST_DONE;
        else               k_d     = k_q + IDX_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active_bank_d = active_bank_q;
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = overrun_q;
    if (state_q == ST_DONE) begin
      active_bank_d = ~active_bank_q;
      frame_cnt_d   = frame_cnt_q + 16'd1;
    end
    if (bus.start && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lat_q         <= '0;
      k_q           <= '0;
      active_bank_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      k_q           <= k_d;
      active_bank_q <= active_bank_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Read select follows the next bank so the read registered on the swap edge already sees the new frame.
  wt_pingpong_bank #(
    .N_WT   (N_WT),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we_i      (cap_we),
    .wr_bank_i (~active_bank_q),
    .wr_slot_i (k_q),
    .wr_data_i (bus.din),
    .rd_bank_i (active_bank_d),
    .rd_addr_i (bus.rd_addr),
    .rd_data_o (bus.rd_data)
  );

  assign bus.frame_done  = (state_q == ST_DONE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.active_bank = active_bank_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_wt_frame_unpacker.sv
// Scoreboard bench for wt_frame_unpacker: directed frames, readout, overrun and mid-frame reset.
module tb_wt_frame_unpacker;
  localparam int NW = 4;
  localparam int DW = 64;
  localparam int RL = 3;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;

  wt_frame_unpacker_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wt_frame_unpacker #(
    .N_WT         (NW),
    .DATA_W       (DW),
    .READ_LATENCY (RL),
    .ADDR_W       (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        bank;
    logic [15:0] cnt;
  } done_t;

  done_t       done_q[$];
  logic [63:0] rd_q[$];
  bit          rd_req   = 1'b0;
  bit          rd_req_s = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        exp_bank = 1'b0;
  logic [15:0] exp_cnt  = 16'd0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: pops expected read data and frame commits as the DUT presents them.
  always @(posedge clk) rd_req_s <= rd_req;

  always @(negedge clk) begin
    done_t d;
    logic [63:0] e;
    if (rd_req_s) begin
      if (rd_q.size() == 0) begin
        chk("rd_scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        e = rd_q.pop_front();
        chk("rd_data", bus.rd_data, e);
      end
    end
    if (bus.frame_done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("unexpected_frame_done", 64'd1, 64'd0);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(d.cyc));
        chk("done_bank_before_swap", bus.active_bank, d.bank);
        chk("done_cnt_before_inc", bus.frame_cnt, d.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [63:0] e);
    bus.rd_addr = a;
    rd_req      = 1'b1;
    rd_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  // Entered just after an edge; start is sampled on the following edge.
  task automatic frame(input logic [63:0] base, input int repulse_k);
    done_t d;
    bus.start = 1'b1;
    d.cyc  = cyc + 1 + RL + NW - 1;
    d.bank = exp_bank;
    d.cnt  = exp_cnt;
    done_q.push_back(d);
    exp_bank = ~exp_bank;
    exp_cnt  = exp_cnt + 16'd1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    repeat (RL - 1) tick();
    for (int k = 0; k < NW; k++) begin
      bus.din   = base + 64'(k);
      bus.start = (k == repulse_k);
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_data"}, bus.rd_data, 64'd0);
    chk({tag, "_frame_done"}, bus.frame_done, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_active_bank"}, bus.active_bank, 1'b0);
    chk({tag, "_overrun"}, bus.overrun, 1'b0);
    chk({tag, "_frame_cnt"}, bus.frame_cnt, 16'd0);
  endtask

  int t0;

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.din     = '0;
    bus.rd_addr = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    tick();
    chk("busy_idle", bus.busy, 1'b0);

    // First frame lands in bank 1.
    frame(64'hA0, -1);
    tick();
    chk("bank_after_a", bus.active_bank, exp_bank);
    chk("cnt_after_a", bus.frame_cnt, exp_cnt);
    chk("busy_after_a", bus.busy, 1'b0);
    for (int a = 0; a < NW; a++) rd(AW'(a), 64'hA0 + 64'(a));
    rd(3'd5, 64'd0);

    // Second frame while addr 2 is read every cycle: old frame until the swap edge.
    t0 = cyc + 1;
    fork
      frame(64'hB0, -1);
      begin
        for (int i = 0; i < 10; i++) begin
          rd(3'd2, (cyc + 1 <= t0 + RL + NW - 1) ? 64'hA2 : 64'hB2);
        end
      end
    join
    chk("bank_after_b", bus.active_bank, exp_bank);
    chk("cnt_after_b", bus.frame_cnt, exp_cnt);

    // Back-to-back frames: second start lands in the IDLE cycle after DONE.
    frame(64'hC0, -1);
    tick();
    frame(64'hD0, -1);
    tick();
    chk("overrun_after_b2b", bus.overrun, 1'b0);
    chk("cnt_after_b2b", bus.frame_cnt, exp_cnt);
    rd(3'd1, 64'hD1);
    rd(3'd3, 64'hD3);

    // Start re-pulsed during CAPTURE is ignored but flagged.
    frame(64'hE0, 1);
    tick();
    chk("overrun_set", bus.overrun, 1'b1);
    chk("cnt_after_e", bus.frame_cnt, exp_cnt);
    for (int a = 0; a < NW; a++) rd(AW'(a), 64'hE0 + 64'(a));
    frame(64'h50, -1);
    tick();
    chk("overrun_sticky", bus.overrun, 1'b1);
    rd(3'd0, 64'h50);

    // Reset mid-CAPTURE discards everything.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (RL - 1) tick();
    bus.din = 64'hF0;
    tick();
    bus.din = 64'hF1;
    tick();
    chk("busy_mid_capture", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    exp_bank = 1'b0;
    exp_cnt  = 16'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rd(3'd0, 64'd0);
    rd(3'd1, 64'd0);

    frame(64'h70, -1);
    tick();
    chk("bank_after_reset_frame", bus.active_bank, 1'b1);
    chk("cnt_after_reset_frame", bus.frame_cnt, 16'd1);
    chk("overrun_after_reset", bus.overrun, 1'b0);
    for (int a = 0; a < NW; a++) rd(AW'(a), 64'h70 + 64'(a));

    repeat (3) tick();
    chk("done_queue_drained", 64'(done_q.size()), 64'd0);
    chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wt_frame_unpacker.md
# wt_frame_unpacker

Downstream consumer of the 64-bit turbine result FIFO stage. On each frame start pulse, the same pulse that triggers the FIFO read burst, it waits a fixed read latency and then captures `N_WT` consecutive 64-bit words, one per wind turbine. The words go into a ping-pong register bank. At frame completion the banks swap, so the network-solution side always reads a complete, coherent frame through an addressed, registered read port.

## Interface
- `N_WT`, default `` `N_WindTurbine`` (4): words per frame, one per turbine; ≥1.
- `DATA_W`, default 64: word width.
- `READ_LATENCY`, default 3: cycles from the start sample edge to the edge that captures the first valid word; ≥1.
- `ADDR_W`, default `$clog2(N_WT)` (min 1): read address width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  frame start pulse, in phase with the FIFO read-burst trigger.
- `din`  in  DATA_W  registered FIFO output word.
- `rd_addr`  in  ADDR_W  turbine index for the readout.
- `rd_data`  out  DATA_W  registered word from the committed bank.
- `frame_done`  out  1  one-cycle pulse; a new frame has been committed.
- `busy`  out  1  high from the start sample until `frame_done`, inclusive.
- `active_bank`  out  1  index of the committed (readable) bank.
- `overrun`  out  1  sticky; `start` arrived while busy.
- `frame_cnt`  out  16  committed frames, modulo 2^16.

## Operation
- FSM states: IDLE, WAIT, CAPTURE, DONE.
- IDLE → WAIT on `start`. If READ_LATENCY=1, IDLE goes straight to CAPTURE.
- WAIT: latency counter runs READ_LATENCY−1 cycles, then → CAPTURE.
- CAPTURE: word index `k` runs 0..N_WT−1. Each cycle writes `din` into capture bank (`~active_bank`) slot `k`. After slot N_WT−1, → DONE.
- DONE (one cycle): `active_bank` toggles, `frame_done`=1, `frame_cnt`+1, then → IDLE.
- `start` in WAIT, CAPTURE or DONE: ignored, and `overrun` sets. `overrun` clears only on `rst`.
- `start` in the IDLE cycle right after DONE is accepted normally.
- Readout: `rd_data` ← bank[`active_bank`][`rd_addr`], one-cycle registered latency.
- `rd_addr` ≥ N_WT: `rd_data` = 0.
- Readout never observes the capture bank. On the DONE edge, the next `rd_data` comes from the newly committed bank.
- `frame_cnt` wraps 65535 → 0.
- Reset values: FSM=IDLE, all bank registers 0, `rd_data`=0, `frame_done`=0, `busy`=0, `active_bank`=0, `overrun`=0, `frame_cnt`=0.
- Reset mid-frame: partial frame discarded. The committed bank is also cleared, because everything resets to 0.

## Timing
- `start` sampled high at edge t.
- Word k captured at edge t+READ_LATENCY+k, for k=0..N_WT−1.
- DONE state occupies the cycle after edge t+READ_LATENCY+N_WT−1. `frame_done` is high in that cycle.
- The bank toggles at edge t+READ_LATENCY+N_WT.
- `busy` is high from the cycle after edge t through the `frame_done` cycle.
- Minimum start-to-start spacing without overrun: READ_LATENCY+N_WT+1 cycles.
- `rd_data` is valid one cycle after `rd_addr` changes.

## Structure
- Shared parameter package: `N_WindTurbine`, the data-width constant, the FSM state encodings, and `READ_LATENCY` = 3. That value matches the FIFO stage path: enable generation, then FIFO q, then output register.
- One natural sub-module: `wt_pingpong_bank`, holding 2×N_WT×DATA_W registers with a write port (bank, slot, data, we) and a registered read port.
- FSM and counters stay in the top level.

## Test plan
- N_WT=4, READ_LATENCY=3. Pulse `start` at edge 10; drive `din`=0xA0..0xA3 at edges 13..16 → `frame_done` in the cycle after edge 16, `active_bank`=1. Reading addrs 0..3 returns 0xA0..0xA3; `frame_cnt`=1.
- Second frame 0xB0..0xB3. While it is being captured, read addr 2 each cycle → 0xA2 until the swap, then 0xB2.
- `start` re-pulsed during CAPTURE → ignored. The frame completes with the original data; `overrun`=1 and stays 1.
- `start` pulsed in the IDLE cycle right after DONE → accepted, `overrun` stays 0. Two back-to-back frames each complete exactly 8 cycles apart.
- `rd_addr`=5 with N_WT=4 → `rd_data`=0.
- Assert `rst` mid-CAPTURE → all outputs return to reset values, no `frame_done` occurs, and the next frame captures correctly into bank 1.
